// File: rtl/modred_iter_ctrl.sv
// Iterative Montgomery reduction sequencer driving one shared external reduction stage.
// Latency L_ITER*STAGE_LAT+1 cycles from accept; the result is held in DONE until out_ready.
module modred_iter_ctrl #(
    parameter int DATA_SIZE = 16,
    parameter int W_SIZE    = 8,
    parameter int L_ITER    = 2,
    parameter int STAGE_LAT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2*DATA_SIZE-1:0]        in_data,
    input  logic [DATA_SIZE-W_SIZE-1:0]   q_h,
    output logic [2*DATA_SIZE:0]          stg_t1,
    output logic [DATA_SIZE-W_SIZE-1:0]   stg_qh,
    input  logic [2*DATA_SIZE:0]          stg_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_SIZE-1:0]          out_data,
    output logic                          busy
);

    localparam int AW = 2*DATA_SIZE + 1;
    localparam int IW = $clog2(L_ITER + 1);
    localparam int CW = $clog2(STAGE_LAT + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(L_ITER - 1);
    localparam logic [CW-1:0] WCNT_LAST = CW'(STAGE_LAT - 1);

    typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

    state_t                        state;
    logic [IW-1:0]                 iter;
    logic [CW-1:0]                 wcnt;
    logic [AW-1:0]                 acc;
    logic [DATA_SIZE-W_SIZE-1:0]   qh_reg;
    logic [AW-1:0]                 q_full;

    // q = qH*2^W + 1, widened to the accumulator width for the final compare
    assign q_full   = AW'({qh_reg, W_SIZE'(1)});
    assign stg_t1   = acc;
    assign stg_qh   = qh_reg;
    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            iter      <= '0;
            wcnt      <= '0;
            acc       <= '0;
            qh_reg    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc    <= AW'(in_data);
                        qh_reg <= q_h;
                        iter   <= '0;
                        wcnt   <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // stg_t1 has been stable for STAGE_LAT cycles only on this count
                    if (wcnt == WCNT_LAST) begin
                        acc  <= stg_c;
                        wcnt <= '0;
                        iter <= iter + IW'(1);
                        if (iter == ITER_LAST)
                            state <= CORR;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                    end
                end
                CORR: begin
                    out_data  <= (acc >= q_full) ? (acc[DATA_SIZE-1:0] - q_full[DATA_SIZE-1:0])
                                                 : acc[DATA_SIZE-1:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
